// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Divider datapath is built only when MULT_DIV_UNIT_DIV_EN is defined.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] rs_data,
  input  logic [N-1:0] rt_data,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [N-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         div_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t         state_q;
  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   hi_q;
  logic [N-1:0]   lo_q;
  logic [N-1:0]   mcand_q;
  logic [2*N-1:0] prod_q;
  logic [CW-1:0]  cnt_q;
  logic           neg_q;

  logic           idle_d;
  logic           accept_d;
  logic           rs_neg_d;
  logic           rt_neg_d;
  logic [N-1:0]   rs_mag_d;
  logic [N-1:0]   rt_mag_d;
  logic [N:0]     mul_sum_d;
  logic [2*N-1:0] mul_next_d;
  logic [2*N-1:0] prod_fix_d;
  logic [N-1:0]   res_hi_d;
  logic [N-1:0]   res_lo_d;

  // busy lags the state by one edge, so the unit only counts as idle once both agree
  assign idle_d   = (state_q == S_IDLE) && !busy_q;
  assign rs_neg_d = ~op[0] & rs_data[N-1];
  assign rt_neg_d = ~op[0] & rt_data[N-1];
  assign rs_mag_d = rs_neg_d ? -rs_data : rs_data;
  assign rt_mag_d = rt_neg_d ? -rt_data : rt_data;

  // prod_q = {partial product, remaining multiplier bits}
  assign mul_sum_d  = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next_d = {mul_sum_d, prod_q[N-1:1]};
  assign prod_fix_d = neg_q ? -prod_q : prod_q;

`ifdef MULT_DIV_UNIT_DIV_EN
  logic           is_div_q;
  logic           rneg_q;
  logic           div_zero_q;
  logic [N:0]     div_shift_d;
  logic [N:0]     div_diff_d;
  logic [2*N-1:0] div_next_d;

  assign accept_d = idle_d & start;

  // prod_q = {partial remainder, dividend bits / quotient bits}
  assign div_shift_d = prod_q[2*N-1:N-1];
  assign div_diff_d  = div_shift_d - {1'b0, mcand_q};
  assign div_next_d  = div_diff_d[N] ? {div_shift_d[N-1:0], prod_q[N-2:0], 1'b0}
                                     : {div_diff_d[N-1:0],  prod_q[N-2:0], 1'b1};
  assign div_zero    = div_zero_q;

  always_comb begin
    res_hi_d = prod_fix_d[2*N-1:N];
    res_lo_d = prod_fix_d[N-1:0];
    if (is_div_q) begin
      res_hi_d = rneg_q ? -prod_q[2*N-1:N] : prod_q[2*N-1:N];
      if (mcand_q == '0) res_lo_d = '1;
      else               res_lo_d = neg_q ? -prod_q[N-1:0] : prod_q[N-1:0];
    end
  end
`else
  assign accept_d = idle_d & start & ~op[1];
  assign div_zero = 1'b0;
  assign res_hi_d = prod_fix_d[2*N-1:N];
  assign res_lo_d = prod_fix_d[N-1:0];
`endif

  always_ff @(negedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
      is_div_q   <= 1'b0;
      rneg_q     <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            prod_q  <= {{N{1'b0}}, op[1] ? rs_mag_d : rt_mag_d};
            mcand_q <= op[1] ? rt_mag_d : rs_mag_d;
            neg_q   <= rs_neg_d ^ rt_neg_d;
            cnt_q   <= '0;
            state_q <= op[1] ? S_DIV : S_MUL;
`ifdef MULT_DIV_UNIT_DIV_EN
            is_div_q   <= op[1];
            rneg_q     <= rs_neg_d;
            div_zero_q <= 1'b0;
`endif
          end else if (idle_d) begin
            if (mthi) hi_q <= wr_data;
            if (mtlo) lo_q <= wr_data;
          end
        end
        S_MUL: begin
          prod_q <= mul_next_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(N-1)) state_q <= S_FIX;
        end
        S_DIV: begin
`ifdef MULT_DIV_UNIT_DIV_EN
          prod_q <= div_next_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(N-1)) state_q <= S_FIX;
`else
          state_q <= S_IDLE;
`endif
        end
        S_FIX: begin
          hi_q    <= res_hi_d;
          lo_q    <= res_lo_d;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
`ifdef MULT_DIV_UNIT_DIV_EN
          if (is_div_q) div_zero_q <= (mcand_q == '0);
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: N, 32, operand/HI/LO width.
REQ-002 clk  in  1  clock; all state updates on falling edge, same edge as the pipeline registers.
REQ-003 reset  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  request op from EX stage; sampled only in IDLE.
REQ-005 op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rs_data  in  N  multiplicand/dividend.
REQ-007 rt_data  in  N  multiplier/divisor.
REQ-008 mthi  in  1  write wr_data to HI.
REQ-009 mtlo  in  1  write wr_data to LO.
REQ-010 wr_data  in  N  MTHI/MTLO data.
REQ-011 busy  out  1  op in progress; hazard unit stalls the pipeline on it.
REQ-012 done  out  1  one-cycle pulse when HI/LO are updated by an op.
REQ-013 hi  out  N  HI register.
REQ-014 lo  out  N  LO register.
REQ-015 div_zero  out  1  last divide had rt_data==0.

Function
REQ-016 FSM states: IDLE, MUL, DIV, FIX; registered outputs only.
REQ-017 IDLE: start=1 with op MULT/MULTU -> MUL; with DIV/DIVU -> DIV; operands latched on the same edge.
REQ-018 Signed ops: operands latched as magnitudes; result sign stored; correction applied in FIX.
REQ-019 MUL: shift-add, one bit per cycle, exactly N cycles, then FIX.
REQ-020 DIV: restoring division, one quotient bit per cycle, exactly N cycles, then FIX.
REQ-021 FIX: sign-correct, write HI/LO, assert done for this cycle only, go to IDLE.
REQ-022 Latency: start sampled on edge k; busy=1 on edges k+1..k+N+1; HI/LO and done valid after edge k+N+1; busy=0 after edge k+N+2.
REQ-023 MULT/MULTU: {HI,LO} = full 2N-bit product.
REQ-024 DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with sign of dividend.
REQ-025 Divide by zero: HI=rs_data, LO=all ones; div_zero=1; no exception.
REQ-026 Signed overflow (most negative / -1): LO=most negative value, HI=0.
REQ-027 div_zero held until the next accepted start; cleared by any accepted start.
REQ-028 start while busy: ignored; no queuing.
REQ-029 mthi/mtlo honoured only in IDLE; ignored while busy.
REQ-030 start and mthi/mtlo in the same IDLE cycle: start wins; the write is dropped.
REQ-031 mthi and mtlo together: both HI and LO take wr_data.
REQ-032 HI/LO hold their value between writes; never change during MUL/DIV.

Reset
REQ-033 reset=0 at a falling edge: state=IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0, internal datapath cleared.
REQ-034 Reset mid-operation aborts the op with no HI/LO write.
REQ-035 reset has priority over start, mthi and mtlo.

Configuration
REQ-036 Macro MULT_DIV_UNIT_DIV_EN.
  Defined: divider datapath built and DIV/DIVU behave per REQ-020..REQ-027.
  Undefined: no divider logic; DIV/DIVU starts ignored (stay IDLE, busy=0, HI/LO unchanged); div_zero tied 0.

Verification (N=32)
REQ-037 MULT rs=0xFFFFFFFF rt=0x00000002 -> busy for 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; done 1 cycle.
REQ-038 MULTU, same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-039 DIV rs=-7 rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 DIVU rs=7 rt=0 -> hi=7, lo=0xFFFFFFFF, div_zero=1; next MULT start -> div_zero=0.
REQ-041 MULT started, second start and mthi at cycle 5 -> both ignored; reset=0 at cycle 10 -> next edge busy=0, hi=lo=0, done never pulses.
REQ-042 Build without MULT_DIV_UNIT_DIV_EN: DIVU start -> busy stays 0, hi/lo unchanged; MULT still per REQ-037.
